corelet_seq: RTL and testbench

CORELET_SEQ -- requirements
Module: corelet_seq

---
 rtl/corelet_seq.sv | 200 ++++++++++++++++++++
 tb/tb_corelet_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/corelet_seq.sv
// Job sequencer for a PE-array corelet: walks a weight/activation job
// through its phases and decodes the 37-bit instruction word each cycle.
module corelet_seq #(
    parameter int row   = 8,
    parameter int col   = 8,
    parameter int len_w = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             os_mode_in,
    input  logic             acc_en,
    input  logic             relu_en,
    input  logic [len_w-1:0] num_vec,
    input  logic             ofifo_valid,
    output logic [36:0]      inst,
    output logic             busy,
    output logic             done
);

    localparam int SPAN = 1 << len_w;
    localparam int M1   = (col > row) ? col : row;
    localparam int M2   = (M1 > SPAN) ? M1 : SPAN;
    localparam int CW   = $clog2(M2);

    localparam logic [CW-1:0] COL_LAST = CW'(col - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(row - 1);

    localparam int B_LOAD  = 0;
    localparam int B_EXE   = 1;
    localparam int B_L0WR  = 2;
    localparam int B_L0RD  = 3;
    localparam int B_IRD   = 4;
    localparam int B_IWR   = 5;
    localparam int B_ORD   = 6;
    localparam int B_ACC   = 33;
    localparam int B_RELU  = 34;
    localparam int B_OS    = 35;
    localparam int B_FLUSH = 36;

    typedef enum logic [3:0] {
        IDLE,
        WL0,
        WKER,
        WGAP,
        XL0,
        XEXE,
        FLUSH,
        DRAIN,
        ACC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             mode_q;
    logic             acc_q;
    logic             relu_q;
    logic [len_w-1:0] n_q;
    logic [CW-1:0]    n_last;
    logic             n_zero;

    assign n_last = CW'(n_q) - CW'(1);
    assign n_zero = (n_q == '0);

    // Every phase transition reloads the counter with 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            acc_q  <= 1'b0;
            relu_q <= 1'b0;
            n_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= os_mode_in;
                        acc_q  <= acc_en;
                        relu_q <= relu_en;
                        n_q    <= num_vec;
                        cnt    <= '0;
                        if (!os_mode_in)
                            state <= WL0;
                        else if (num_vec == '0)
                            state <= FLUSH;
                        else
                            state <= XL0;
                    end
                end
                WL0: begin
                    if (cnt == COL_LAST) begin
                        state <= WKER;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WKER: begin
                    if (cnt == COL_LAST) begin
                        state <= WGAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WGAP: begin
                    state <= n_zero ? DONE : XL0;
                    cnt   <= '0;
                end
                XL0: begin
                    if (cnt == n_last) begin
                        state <= XEXE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                XEXE: begin
                    if (cnt == n_last) begin
                        state <= mode_q ? FLUSH : DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FLUSH: begin
                    if (cnt == ROW_LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Only cycles that actually pop the output FIFO advance.
                DRAIN: begin
                    if (ofifo_valid) begin
                        if (cnt == n_last) begin
                            state <= acc_q ? ACC : DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ACC: begin
                    if (cnt == n_last) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // ofifo_rd is the one bit gated by an input: a read must never be
    // issued against an empty output FIFO.
    always_comb begin
        inst = '0;
        busy = (state != IDLE);
        done = (state == DONE);
        if (state != IDLE)
            inst[B_OS] = mode_q;
        unique case (state)
            WL0: inst[B_L0WR] = 1'b1;
            WKER: begin
                inst[B_L0RD] = 1'b1;
                inst[B_LOAD] = 1'b1;
            end
            XL0: begin
                inst[B_L0WR] = 1'b1;
                inst[B_IWR]  = mode_q;
            end
            XEXE: begin
                inst[B_L0RD] = 1'b1;
                inst[B_EXE]  = 1'b1;
                inst[B_IRD]  = mode_q;
            end
            FLUSH: inst[B_FLUSH] = 1'b1;
            DRAIN: inst[B_ORD] = ofifo_valid;
            ACC: begin
                inst[B_ACC]  = 1'b1;
                inst[B_RELU] = relu_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_corelet_seq.sv
// Scoreboard bench for corelet_seq: a phase-list model predicts the
// per-cycle {done, busy, inst} trace of every job.
module tb_corelet_seq;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int LW  = 7;

    localparam logic [36:0] LOAD = 37'd1 << 0;
    localparam logic [36:0] EXE  = 37'd1 << 1;
    localparam logic [36:0] L0W  = 37'd1 << 2;
    localparam logic [36:0] L0R  = 37'd1 << 3;
    localparam logic [36:0] IRD  = 37'd1 << 4;
    localparam logic [36:0] IWR  = 37'd1 << 5;
    localparam logic [36:0] ORD  = 37'd1 << 6;
    localparam logic [36:0] ACCB = 37'd1 << 33;
    localparam logic [36:0] RELU = 37'd1 << 34;
    localparam logic [36:0] OSB  = 37'd1 << 35;
    localparam logic [36:0] FLB  = 37'd1 << 36;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          os_mode_in;
    logic          acc_en;
    logic          relu_en;
    logic [LW-1:0] num_vec;
    logic          ofifo_valid;
    logic [36:0]   inst;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int k_now    = 0;
    int done_at  = -1;

    logic [38:0] exp_q[$];
    logic [38:0] trace[$];
    bit          pat[0:511];

    always #5 clk = ~clk;

    corelet_seq #(.row(ROW), .col(COL), .len_w(LW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .os_mode_in(os_mode_in),
        .acc_en(acc_en),
        .relu_en(relu_en),
        .num_vec(num_vec),
        .ofifo_valid(ofifo_valid),
        .inst(inst),
        .busy(busy),
        .done(done)
    );

    // Monitor: pops one expected word per cycle while any are queued.
    always @(negedge clk) begin : mon
        logic [38:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({done, busy, inst} !== e) begin
                failures++;
                $display("FAIL trace k=%0d got=%h exp=%h",
                         k_now, {done, busy, inst}, e);
            end
        end
        checks++;
        if (inst[6] && !ofifo_valid) begin
            failures++;
            $display("FAIL ofifo_rd_empty k=%0d got=1 exp=0", k_now);
        end
        if (done && done_at < 0)
            done_at = k_now;
    end

    function automatic void put(bit d, bit b, logic [36:0] i);
        trace.push_back({d, b, i});
    endfunction

    // Trace index k is the cycle number, k=0 being the start cycle.
    function automatic void build(bit os, bit acc, bit relu, int n);
        logic [36:0] m;
        int rd;
        bit v;
        m = os ? OSB : 37'd0;
        trace.delete();
        put(0, 0, 37'd0);
        if (!os) begin
            repeat (COL) put(0, 1, m | L0W);
            repeat (COL) put(0, 1, m | L0R | LOAD);
            put(0, 1, m);
        end
        if (n > 0) begin
            repeat (n) put(0, 1, m | L0W | (os ? IWR : 37'd0));
            repeat (n) put(0, 1, m | L0R | EXE | (os ? IRD : 37'd0));
        end
        if (os) begin
            repeat (ROW) put(0, 1, m | FLB);
        end else if (n > 0) begin
            rd = 0;
            while (rd < n) begin
                v = pat[trace.size()];
                put(0, 1, m | (v ? ORD : 37'd0));
                rd += int'(v);
            end
            if (acc)
                repeat (n) put(0, 1, m | ACCB | (relu ? RELU : 37'd0));
        end
        put(1, 1, m);
    endfunction

    task automatic idle_cyc(input bit rst);
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        reset       = rst;
        start       = 1'b0;
        ofifo_valid = 1'($urandom);
    endtask

    task automatic run_job(input bit os, input bit acc, input bit relu,
                           input int n, input int kind,
                           input int abort_at, input int exp_done);
        int len;
        int last;
        for (int k = 0; k < 512; k++) begin
            case (kind)
                0: pat[k] = 1'b1;
                1: pat[k] = (k < 26) ? 1'b1 : ((k - 26) % 2 == 0);
                default: pat[k] = (k >= 300) ? 1'b1 : 1'($urandom);
            endcase
        end
        build(os, acc, relu, n);
        len = trace.size();
        if (abort_at > 0) begin
            while (trace.size() > abort_at + 1)
                void'(trace.pop_back());
            trace.push_back('0);
        end
        foreach (trace[i]) exp_q.push_back(trace[i]);
        @(posedge clk);
        #1;
        k_now       = 0;
        done_at     = -1;
        start       = 1'b1;
        os_mode_in  = os;
        acc_en      = acc;
        relu_en     = relu;
        num_vec     = LW'(n);
        ofifo_valid = pat[0];
        last = (abort_at > 0) ? abort_at + 2 : len;
        for (int k = 1; k < last; k++) begin
            @(posedge clk);
            #1;
            k_now       = k;
            start       = ($urandom_range(0, 4) == 0);
            os_mode_in  = 1'($urandom);
            acc_en      = 1'($urandom);
            relu_en     = 1'($urandom);
            num_vec     = LW'($urandom);
            ofifo_valid = pat[k];
            if (abort_at > 0 && k == abort_at) begin
                reset = 1'b1;
                start = 1'b1;
            end
            if (abort_at > 0 && k == abort_at + 1) begin
                reset = 1'b0;
                start = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        if (exp_done >= 0) begin
            checks++;
            if (done_at != exp_done) begin
                failures++;
                $display("FAIL done_cycle got=%0d exp=%0d",
                         done_at, exp_done);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        reset       = 1'b1;
        start       = 1'b0;
        os_mode_in  = 1'b0;
        acc_en      = 1'b0;
        relu_en     = 1'b0;
        num_vec     = '0;
        ofifo_valid = 1'b0;
        idle_cyc(1);
        idle_cyc(1);
        idle_cyc(0);
        run_job(0, 0, 0, 4, 0, 0, 30);
        idle_cyc(0);
        run_job(0, 1, 1, 4, 0, 0, 34);
        run_job(1, 0, 0, 3, 0, 0, 15);
        idle_cyc(0);
        run_job(0, 0, 0, 4, 1, 0, 33);
        run_job(0, 0, 0, 4, 0, 22, -1);
        run_job(0, 0, 0, 2, 2, 0, -1);
        run_job(0, 0, 0, 0, 0, 0, 18);
        run_job(1, 0, 0, 0, 0, 0, 9);
        run_job(0, 1, 0, 5, 2, 0, -1);
        repeat (25) begin
            run_job(1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 12), 2, 0, -1);
            repeat ($urandom_range(0, 2)) idle_cyc(0);
        end
        idle_cyc(0);
        w = 0;
        while (exp_q.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
